// File: rtl/button_repeat_pulser_pkg.sv
// rtl/button_repeat_pulser_pkg.sv - shared state encodings and 100 MHz timing defaults
package button_repeat_pulser_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_REPEAT  = 2'd2;

    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/button_repeat_pulser_edge_detect.sv
// rtl/button_repeat_pulser_edge_detect.sv - previous-level register with rise/fall strobes
module button_repeat_pulser_edge_detect #(
    parameter bit RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // Resetting to 1 keeps a level that is already high through reset from looking like a new edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= RESET_VALUE;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/button_repeat_pulser.sv
// rtl/button_repeat_pulser.sv - press/auto-repeat tick generator for the RTC adjust buttons
module button_repeat_pulser
    import button_repeat_pulser_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter bit EN_REPEAT     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic tick,
    output logic held,
    output logic release_pulse
);

    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_d;
    logic             release_d;

    button_repeat_pulser_edge_detect #(
        .RESET_VALUE(1'b1)
    ) u_edge (
        .clk  (clk),
        .reset(reset),
        .d    (db),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tick_d    = 1'b0;
        release_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    tick_d  = 1'b1;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                // A release in the same cycle the hold expires wins over the repeat tick.
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (EN_REPEAT) begin
                    tick_d  = 1'b1;
                    cnt_d   = CNT_W'(REPEAT_CYCLES - 1);
                    state_d = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    tick_d = 1'b1;
                    cnt_d  = CNT_W'(REPEAT_CYCLES - 1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            tick          <= 1'b0;
            held          <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            tick          <= tick_d;
            held          <= (state_d == ST_REPEAT);
            release_pulse <= release_d;
        end
    end

endmodule

// File: tb/tb_button_repeat_pulser.sv
// tb/tb_button_repeat_pulser.sv - scoreboard bench for button_repeat_pulser, repeat on and off
module tb_button_repeat_pulser;

    localparam int H = 20;
    localparam int R = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic db    = 1'b0;
    logic tick0, held0, rel0;
    logic tick1, held1, rel1;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt[2];

    logic [5:0] exp_q[$];
    logic       m_prev;
    logic       m_active[2];
    int         m_age[2];

    always #5 clk = ~clk;

    button_repeat_pulser #(
        .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CNT_W(5), .EN_REPEAT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .db(db),
        .tick(tick0), .held(held0), .release_pulse(rel0)
    );

    button_repeat_pulser #(
        .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CNT_W(5), .EN_REPEAT(1'b0)
    ) dut_norep (
        .clk(clk), .reset(reset), .db(db),
        .tick(tick1), .held(held1), .release_pulse(rel1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: age = clock edges since the press tick; repeats land at H, H+R, H+2R, ...
    task automatic model_edge();
        logic [5:0] e;
        e = '0;
        if (!reset) begin
            m_prev      = 1'b1;
            m_active[0] = 1'b0;
            m_active[1] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit   en;
                logic t, h, r;
                en = (i == 0);
                t = 1'b0; h = 1'b0; r = 1'b0;
                if (m_active[i]) begin
                    if (!db) begin
                        r           = 1'b1;
                        m_active[i] = 1'b0;
                    end else begin
                        m_age[i]++;
                        if (en && m_age[i] >= H && ((m_age[i] - H) % R) == 0) t = 1'b1;
                        h = en && (m_age[i] >= H);
                    end
                end else if (db && !m_prev) begin
                    t           = 1'b1;
                    m_active[i] = 1'b1;
                    m_age[i]    = 0;
                end
                e[i*3 +: 3] = {t, h, r};
            end
            m_prev = db;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        logic [5:0] e;
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq("tick",          32'(tick0), 32'(e[2]));
            check_eq("held",          32'(held0), 32'(e[1]));
            check_eq("release",       32'(rel0),  32'(e[0]));
            check_eq("tick_norep",    32'(tick1), 32'(e[5]));
            check_eq("held_norep",    32'(held1), 32'(e[4]));
            check_eq("release_norep", 32'(rel1),  32'(e[3]));
            tick_cnt[0] += int'(tick0);
            tick_cnt[1] += int'(tick1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_tick"},    32'(tick0), 32'd0);
        check_eq({tag, "_held"},    32'(held0), 32'd0);
        check_eq({tag, "_release"}, 32'(rel0),  32'd0);
        check_eq({tag, "_tick_nr"}, 32'(tick1), 32'd0);
        check_eq({tag, "_rel_nr"},  32'(rel1),  32'd0);
    endtask

    initial begin
        m_prev      = 1'b1;
        m_active[0] = 1'b0;
        m_active[1] = 1'b0;
        m_age[0]    = 0;
        m_age[1]    = 0;
        tick_cnt[0] = 0;
        tick_cnt[1] = 0;

        #12;
        check_outputs_zero("reset");
        step(2);
        reset = 1'b1;
        step(50);

        db = 1'b1; step(10);
        db = 1'b0; step(5);

        tick_cnt[0] = 0;
        tick_cnt[1] = 0;
        db = 1'b1; step(40);
        db = 1'b0; step(5);
        check_eq("hold40_ticks",       32'(tick_cnt[0]), 32'd5);
        check_eq("hold40_ticks_norep", 32'(tick_cnt[1]), 32'd1);

        // Release lands exactly on the edge where the hold counter has reached zero.
        db = 1'b1; step(H);
        db = 1'b0; step(4);

        db = 1'b1; step(30);
        check_eq("held_before_reset", 32'(held0), 32'd1);
        #2 reset = 1'b0;
        #1 check_outputs_zero("async_reset");
        step(3);
        reset = 1'b1;
        step(10);
        db = 1'b0; step(3);
        db = 1'b1; step(5);
        db = 1'b0; step(3);

        db = 1'b1; step(1);
        db = 1'b0; step(3);

        for (int k = 0; k < 30; k++) begin
            db = ~db;
            step($urandom_range(1, 30));
        end
        db = 1'b0; step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
